// File: rtl/cs_pkg.sv
// Shared definitions for the column-contribution argmax stage: FSM states,
// width helpers and the default Q-format fractional width.
package cs_pkg;

  localparam int unsigned FRAC_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_Y,
    MAC,
    FINISH
  } cs_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int row_w(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  function automatic int acc_w(input int data_w, input int m);
    return 2 * data_w + $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/contribution_argmax_seq_if.sv
// Measurement stream, mask and result bundle of contribution_argmax_seq.
interface contribution_argmax_seq_if
  import cs_pkg::*;
#(
  parameter int M      = 3,
  parameter int N      = 4,
  parameter int DATA_W = 32,
  parameter int IDX_W  = idx_w(N),
  parameter int ACC_W  = acc_w(DATA_W, M)
);
  logic                     y_valid;
  logic                     y_ready;
  logic signed [DATA_W-1:0] y_data;
  logic [N-1:0]             col_mask;
  logic                     busy;
  logic                     done;
  logic [IDX_W-1:0]         col_no;
  logic [ACC_W-2:0]         col_val;
  logic                     none_valid;

  modport master (
    output y_valid, y_data, col_mask,
    input  y_ready, busy, done, col_no, col_val, none_valid
  );

  modport slave (
    input  y_valid, y_data, col_mask,
    output y_ready, busy, done, col_no, col_val, none_valid
  );
endinterface

// File: rtl/contrib_mac_unit.sv
// Signed multiply-accumulate with synchronous clear-on-load and an
// absolute-value view of the accumulator.
module contrib_mac_unit #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 67
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic [ACC_W-2:0]         mag
);
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc;

  assign prod     = a * b;
  assign prod_ext = ACC_W'(prod);

  // clr loads the first product of a column instead of adding to stale data
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= clr ? prod_ext : acc + prod_ext;
    end
  end

  assign mag = (ACC_W-1)'(acc[ACC_W-1] ? -acc : acc);
endmodule

// File: rtl/contribution_argmax_seq.sv
// Column-contribution stage: c_j = sum_i A[i][j]*y[i] on one shared MAC,
// then argmax of |c_j| over the columns left open by col_mask.
module contribution_argmax_seq
  import cs_pkg::*;
#(
  parameter int M      = 3,
  parameter int N      = 4,
  parameter int DATA_W = 32,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int IDX_W  = idx_w(N),
  parameter int ACC_W  = acc_w(DATA_W, M)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_we,
  input  logic [row_w(M)-1:0]      a_row,
  input  logic [IDX_W-1:0]         a_col,
  input  logic signed [DATA_W-1:0] a_wdata,
  contribution_argmax_seq_if.slave bus
);
  localparam int ROW_W = row_w(M);

  if (M < 1 || N < 2 || FRAC_W < 0 || FRAC_W >= DATA_W) begin : g_param_chk
    $error("contribution_argmax_seq: illegal parameter combination");
  end

  cs_state_t                state;
  logic [ROW_W-1:0]         r;
  logic [IDX_W-1:0]         c;
  logic signed [DATA_W-1:0] mat [M][N];
  logic signed [DATA_W-1:0] yv  [M];
  logic [N-1:0]             mask_q;
  logic                     cmp_v;
  logic [IDX_W-1:0]         cmp_col;
  logic                     have_best;
  logic [ACC_W-2:0]         best_mag;
  logic [IDX_W-1:0]         best_col;
  logic [ACC_W-2:0]         mac_mag;
  logic                     y_fire;
  logic                     upd;

  assign y_fire = bus.y_valid && bus.y_ready;

  always_ff @(posedge clk) begin
    if (a_we && !bus.busy && int'(a_row) < M && int'(a_col) < N) begin
      mat[a_row][a_col] <= a_wdata;
    end
    if (y_fire) begin
      yv[r] <= bus.y_data;
    end
    if (y_fire && state == IDLE) begin
      mask_q <= bus.col_mask;
    end
  end

  contrib_mac_unit #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk(clk),
    .rst(rst),
    .en (state == MAC),
    .clr(r == '0),
    .a  (mat[r][c]),
    .b  (yv[r]),
    .mag(mac_mag)
  );

  // A column's sum lands in the accumulator one cycle after its last product,
  // so the compare trails the MAC by one cycle and FINISH waits for it.
  assign upd = cmp_v && !mask_q[cmp_col] && (!have_best || mac_mag > best_mag);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      r           <= '0;
      c           <= '0;
      cmp_v       <= 1'b0;
      cmp_col     <= '0;
      have_best   <= 1'b0;
      best_mag    <= '0;
      best_col    <= '0;
      bus.y_ready <= 1'b1;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.col_no  <= '0;
      bus.col_val <= '0;
      bus.none_valid <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      cmp_v    <= (state == MAC) && (r == ROW_W'(M - 1));
      cmp_col  <= c;
      if (upd) begin
        have_best <= 1'b1;
        best_mag  <= mac_mag;
        best_col  <= cmp_col;
      end
      case (state)
        IDLE: begin
          if (y_fire) begin
            bus.busy  <= 1'b1;
            have_best <= 1'b0;
            if (M == 1) begin
              state       <= MAC;
              bus.y_ready <= 1'b0;
            end else begin
              r     <= ROW_W'(1);
              state <= LOAD_Y;
            end
          end
        end
        LOAD_Y: begin
          if (y_fire) begin
            if (r == ROW_W'(M - 1)) begin
              r           <= '0;
              state       <= MAC;
              bus.y_ready <= 1'b0;
            end else begin
              r <= r + 1'b1;
            end
          end
        end
        MAC: begin
          if (r == ROW_W'(M - 1)) begin
            r <= '0;
            if (c == IDX_W'(N - 1)) begin
              c     <= '0;
              state <= FINISH;
            end else begin
              c <= c + 1'b1;
            end
          end else begin
            r <= r + 1'b1;
          end
        end
        FINISH: begin
          if (!cmp_v) begin
            bus.done       <= 1'b1;
            bus.busy       <= 1'b0;
            bus.y_ready    <= 1'b1;
            bus.none_valid <= !have_best;
            bus.col_no     <= have_best ? best_col : '0;
            bus.col_val    <= have_best ? best_mag : '0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_contribution_argmax_seq.sv
// Bench for contribution_argmax_seq: directed 3x4 scenarios plus 200 random
// 5x8 jobs, all compared against a column-sum argmax model.
module tb_contribution_argmax_seq;
  typedef logic signed [127:0] wide_t;
  typedef struct {
    int    col;
    wide_t val;
    bit    none;
    int    acc_edge;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  bit active = 1'b0;

  logic rst0, rst1;
  logic a_we0, a_we1;
  logic [1:0] a_row0;
  logic [2:0] a_row1;
  logic [1:0] a_col0;
  logic [2:0] a_col1;
  logic signed [31:0] a_wdata0, a_wdata1;

  contribution_argmax_seq_if #(.M(3), .N(4), .DATA_W(32)) if0 ();
  contribution_argmax_seq_if #(.M(5), .N(8), .DATA_W(32)) if1 ();

  contribution_argmax_seq #(.M(3), .N(4), .DATA_W(32), .FRAC_W(16)) d0 (
    .clk(clk), .rst(rst0), .a_we(a_we0), .a_row(a_row0), .a_col(a_col0),
    .a_wdata(a_wdata0), .bus(if0)
  );
  contribution_argmax_seq #(.M(5), .N(8), .DATA_W(32), .FRAC_W(16)) d1 (
    .clk(clk), .rst(rst1), .a_we(a_we1), .a_row(a_row1), .a_col(a_col1),
    .a_wdata(a_wdata1), .bus(if1)
  );

  wide_t mA0 [8][8];
  wide_t mY0 [8];
  wide_t mA1 [8][8];
  wide_t mY1 [8];
  exp_t q0[$];
  exp_t q1[$];
  exp_t h0, h1;
  int dn0 = 0;
  int dn1 = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input int m, input int n, input wide_t a[8][8],
                                 input wide_t y[8], input logic [7:0] mask);
    exp_t  e;
    wide_t s, mg, best;
    bit    have;
    have = 1'b0;
    best = 0;
    e.col = 0;
    e.acc_edge = 0;
    for (int j = 0; j < n; j++) begin
      s = 0;
      for (int i = 0; i < m; i++) s += a[i][j] * y[i];
      mg = (s < 0) ? -s : s;
      if (!mask[j] && (!have || mg > best)) begin
        have  = 1'b1;
        best  = mg;
        e.col = j;
      end
    end
    e.none = !have;
    e.val  = have ? best : 0;
    return e;
  endfunction

  function automatic wide_t rnd_val();
    int t;
    if ($urandom_range(0, 1) == 1) t = $urandom;
    else t = (int'($urandom_range(0, 8)) - 4) * 65536;
    return wide_t'(t);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (active) begin
      if (if0.done) begin
        if (q0.size() == 0) begin
          chk("done0_unexpected", if0.done, 0);
        end else begin
          e = q0.pop_front();
          chk("col_no0", if0.col_no, e.col);
          chk("col_val0", if0.col_val, e.val);
          chk("none0", if0.none_valid, e.none);
          chk("latency0", cyc - e.acc_edge, 14);
          h0 = e;
          dn0++;
        end
      end else begin
        chk("hold_col_no0", if0.col_no, h0.col);
        chk("hold_col_val0", if0.col_val, h0.val);
        chk("hold_none0", if0.none_valid, h0.none);
      end
      if (rst0) begin
        h0.col = 0; h0.val = 0; h0.none = 0;
      end
      if (if1.done) begin
        if (q1.size() == 0) begin
          chk("done1_unexpected", if1.done, 0);
        end else begin
          e = q1.pop_front();
          chk("col_no1", if1.col_no, e.col);
          chk("col_val1", if1.col_val, e.val);
          chk("none1", if1.none_valid, e.none);
          chk("latency1", cyc - e.acc_edge, 42);
          h1 = e;
          dn1++;
        end
      end else begin
        chk("hold_col_no1", if1.col_no, h1.col);
        chk("hold_col_val1", if1.col_val, h1.val);
        chk("hold_none1", if1.none_valid, h1.none);
      end
    end
  end

  task automatic wr0(input int row, input int col, input wide_t v, input bit upd);
    a_we0 = 1'b1; a_row0 = 2'(row); a_col0 = 2'(col); a_wdata0 = v[31:0];
    tick();
    a_we0 = 1'b0;
    if (upd) mA0[row][col] = v;
  endtask

  task automatic wr1(input int row, input int col, input wide_t v, input bit upd);
    a_we1 = 1'b1; a_row1 = 3'(row); a_col1 = 3'(col); a_wdata1 = v[31:0];
    tick();
    a_we1 = 1'b0;
    if (upd) mA1[row][col] = v;
  endtask

  task automatic out0(input string name, input int col, input wide_t val, input bit none);
    chk({name, "_col_no"}, if0.col_no, col);
    chk({name, "_col_val"}, if0.col_val, val);
    chk({name, "_none"}, if0.none_valid, none);
  endtask

  task automatic job0(input logic [3:0] mask, input int gap, input bit wr_mid, input int abort);
    exp_t e;
    int k, start;
    e = model(3, 4, mA0, mY0, {4'b0, mask});
    for (int i = 0; i < 3; i++) begin
      if0.y_valid  = 1'b1;
      if0.y_data   = mY0[i][31:0];
      if0.col_mask = (i == 0) ? mask : ~mask;
      k = 0;
      while (!if0.y_ready && k < 50) begin tick(); k++; end
      if (k >= 50) chk("y_ready0_timeout", if0.y_ready, 1);
      e.acc_edge = cyc + 1;
      tick();
      if0.y_valid = 1'b0;
      if (i < 2) repeat (gap) tick();
    end
    start = dn0;
    if (abort > 0) begin
      repeat (abort) tick();
      rst0 = 1'b1;
      tick();
      rst0 = 1'b0;
      chk("abort_busy", if0.busy, 0);
      chk("abort_y_ready", if0.y_ready, 1);
      chk("abort_done", if0.done, 0);
      out0("abort", 0, 0, 0);
      repeat (20) tick();
      chk("abort_no_done", dn0, start);
      return;
    end
    q0.push_back(e);
    if (wr_mid) begin
      repeat (3) tick();
      chk("wr_mid_busy", if0.busy, 1);
      wr0(0, 2, wide_t'(196608), 1'b0);
    end
    k = 0;
    while (dn0 == start && k < 60) begin tick(); k++; end
    if (dn0 == start) chk("done0_timeout", dn0, start + 1);
  endtask

  task automatic job1(input logic [7:0] mask, input int gap, input bit wr_same, input bit wr_mid);
    exp_t  e;
    int    k, start, wr_r, wr_c;
    wide_t wv;
    wr_r = $urandom_range(0, 4);
    wr_c = $urandom_range(0, 7);
    wv   = rnd_val();
    for (int i = 0; i < 5; i++) begin
      if1.y_valid  = 1'b1;
      if1.y_data   = mY1[i][31:0];
      if1.col_mask = (i == 0) ? mask : 8'($urandom);
      if (i == 0 && wr_same) begin
        a_we1 = 1'b1; a_row1 = 3'(wr_r); a_col1 = 3'(wr_c); a_wdata1 = wv[31:0];
      end
      k = 0;
      while (!if1.y_ready && k < 80) begin tick(); k++; end
      if (k >= 80) chk("y_ready1_timeout", if1.y_ready, 1);
      e.acc_edge = cyc + 1;
      tick();
      if1.y_valid = 1'b0;
      a_we1 = 1'b0;
      if (i < 4) repeat (gap) tick();
    end
    if (wr_same) mA1[wr_r][wr_c] = wv;
    begin
      exp_t m;
      m = model(5, 8, mA1, mY1, mask);
      m.acc_edge = e.acc_edge;
      q1.push_back(m);
    end
    start = dn1;
    if (wr_mid) begin
      repeat (5) tick();
      wr1($urandom_range(0, 4), $urandom_range(0, 7), rnd_val(), 1'b0);
    end
    k = 0;
    while (dn1 == start && k < 100) begin tick(); k++; end
    if (dn1 == start) chk("done1_timeout", dn1, start + 1);
  endtask

  initial begin
    exp_t pin;
    int rows0 [3][4] = '{'{32768, -98304, -49152, -57344},
                         '{49152, 32768, -49152, -81920},
                         '{49152, -8192, 90112, 16384}};
    rst0 = 1'b1; rst1 = 1'b1;
    a_we0 = 1'b0; a_we1 = 1'b0;
    a_row0 = '0; a_row1 = '0; a_col0 = '0; a_col1 = '0;
    a_wdata0 = '0; a_wdata1 = '0;
    if0.y_valid = 1'b0; if0.y_data = '0; if0.col_mask = '0;
    if1.y_valid = 1'b0; if1.y_data = '0; if1.col_mask = '0;
    h0.col = 0; h0.val = 0; h0.none = 0; h0.acc_edge = 0;
    h1 = h0;
    for (int i = 0; i < 8; i++) begin
      mY0[i] = 0; mY1[i] = 0;
      for (int j = 0; j < 8; j++) begin mA0[i][j] = 0; mA1[i][j] = 0; end
    end
    repeat (3) tick();
    rst0 = 1'b0; rst1 = 1'b0;
    active = 1'b1;
    chk("rst_y_ready0", if0.y_ready, 1);
    chk("rst_busy0", if0.busy, 0);
    chk("rst_done0", if0.done, 0);
    out0("rst0", 0, 0, 0);
    chk("rst_y_ready1", if1.y_ready, 1);
    chk("rst_busy1", if1.busy, 0);

    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 4; j++) wr0(i, j, wide_t'(rows0[i][j]), 1'b1);
    mY0[0] = 131072; mY0[1] = -65536; mY0[2] = 262144;
    pin = model(3, 4, mA0, mY0, 8'h00);
    chk("model_pin_col", pin.col, 2);
    chk("model_pin_val", pin.val, 128'h4_C000_0000);
    pin = model(3, 4, mA0, mY0, 8'h04);
    chk("model_pin_mask_val", pin.val, 128'h4_0000_0000);

    job0(4'b0000, 0, 1'b0, 0); out0("scen1", 2, 128'h4_C000_0000, 0);
    job0(4'b0100, 0, 1'b0, 0); out0("mask_c2", 1, 128'h4_0000_0000, 0);
    mY0[0] = 0; mY0[1] = 0; mY0[2] = 0;
    job0(4'b0000, 0, 1'b0, 0); out0("zero_y", 0, 0, 0);
    job0(4'b0001, 0, 1'b0, 0); out0("zero_y_m1", 1, 0, 0);
    mY0[0] = 131072; mY0[1] = -65536; mY0[2] = 262144;
    job0(4'b1111, 0, 1'b0, 0); out0("all_masked", 0, 0, 1);
    job0(4'b0000, 2, 1'b0, 0); out0("gaps", 2, 128'h4_C000_0000, 0);
    job0(4'b0000, 0, 1'b1, 0); out0("wr_mid", 2, 128'h4_C000_0000, 0);
    mY0[0] = 65536; mY0[1] = 0; mY0[2] = 0;
    job0(4'b0000, 0, 1'b0, 0); out0("readback", 1, 128'h1_8000_0000, 0);
    mY0[0] = 131072; mY0[1] = -65536; mY0[2] = 262144;
    job0(4'b0000, 0, 1'b0, 6);
    job0(4'b0000, 0, 1'b0, 0); out0("after_abort", 2, 128'h4_C000_0000, 0);

    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 8; j++) wr1(i, j, rnd_val(), 1'b1);
    for (int jn = 0; jn < 200; jn++) begin
      int nw;
      logic [7:0] mask;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) wr1($urandom_range(0, 4), $urandom_range(0, 7), rnd_val(), 1'b1);
      if ($urandom_range(0, 4) == 0) wr1($urandom_range(5, 7), $urandom_range(0, 7), rnd_val(), 1'b0);
      for (int i = 0; i < 5; i++) mY1[i] = rnd_val();
      mask = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom & $urandom);
      job1(mask, $urandom_range(0, 2), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end
    chk("jobs1_done", dn1, 200);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
